cdb_arbiter: RTL and testbench

- Arbitrates completing functional-unit results onto the N_WAY-wide common data bus (CDB) of the R10K-style out-of-order core.
- Sits between the execute-stage functional units and the ROB/reservation-station/map-table wakeup logic.
- Grants up to N_CDB requesters per cycle using rotating round-robin priority, then drives registered CDB broadcasts one cycle later.
- Applies backpressure to losing requesters through a valid/grant handshake.

---
 rtl/cdb_arbiter.sv | 103 ++++++++++
 tb/tb_cdb_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: rotating round-robin grant of up to N_CDB
// completing FU results, broadcast from a register one cycle later.
module cdb_arbiter #(
    parameter int N_REQ    = 4,
    parameter int N_CDB    = 2,
    parameter int TAG_BITS = 6,
    parameter int XLEN     = 32,
    localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW      = $clog2(N_CDB) + 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ-1:0][TAG_BITS-1:0]     req_tag,
    input  logic [N_REQ-1:0][XLEN-1:0]         req_data,
    output logic [N_REQ-1:0]                   req_grant,
    input  logic                               cdb_stall,
    input  logic                               flush,
    output logic [N_CDB-1:0]                   cdb_valid,
    output logic [N_CDB-1:0][TAG_BITS-1:0]     cdb_tag,
    output logic [N_CDB-1:0][XLEN-1:0]         cdb_data,
    output logic [CW-1:0]                      grant_count,
    output logic [PW-1:0]                      rr_ptr
);

    logic [N_REQ-1:0] eligible;
    logic [PW:0]      scan;
    logic [PW-1:0]    idx;
    logic [PW-1:0]    last_idx;
    logic [PW-1:0]    ptr_next;
    logic [CW-1:0]    cnt;
    logic [N_CDB-1:0] slot_hit;
    logic [PW-1:0]    slot_sel [N_CDB];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (req_tag[i] != '0);
        end
    end

    // Scan from rr_ptr with explicit wrap so non-power-of-two N_REQ works.
    always_comb begin
        req_grant = '0;
        cnt       = '0;
        scan      = '0;
        idx       = '0;
        last_idx  = rr_ptr;
        slot_hit  = '0;
        for (int k = 0; k < N_CDB; k++) begin
            slot_sel[k] = '0;
        end
        if (!reset && !flush && !cdb_stall) begin
            for (int j = 0; j < N_REQ; j++) begin
                scan = {1'b0, rr_ptr} + (PW+1)'(j);
                if (scan >= (PW+1)'(N_REQ)) begin
                    scan = scan - (PW+1)'(N_REQ);
                end
                idx = scan[PW-1:0];
                if (eligible[idx] && cnt < CW'(N_CDB)) begin
                    req_grant[idx] = 1'b1;
                    for (int k = 0; k < N_CDB; k++) begin
                        if (cnt == CW'(k)) begin
                            slot_hit[k] = 1'b1;
                            slot_sel[k] = idx;
                        end
                    end
                    last_idx = idx;
                    cnt      = cnt + CW'(1);
                end
            end
        end
    end

    assign grant_count = cnt;

    always_comb begin
        if (last_idx == PW'(N_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = last_idx + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            rr_ptr    <= '0;
        end else if (!cdb_stall) begin
            // Empty slots are zeroed so each broadcast lasts one cycle.
            for (int k = 0; k < N_CDB; k++) begin
                cdb_valid[k] <= slot_hit[k];
                cdb_tag[k]   <= slot_hit[k] ? req_tag[slot_sel[k]] : '0;
                cdb_data[k]  <= slot_hit[k] ? req_data[slot_sel[k]] : '0;
            end
            if (cnt != '0) begin
                rr_ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: behavioural round-robin model checked
// every cycle, plus hand-computed expectations from the test plan.
module tb_cdb_arbiter;

    localparam int N_REQ = 4;
    localparam int N_CDB = 2;
    localparam int TB    = 6;
    localparam int XL    = 32;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ-1:0][TB-1:0] req_tag = '0;
    logic [N_REQ-1:0][XL-1:0] req_data = '0;
    logic [N_REQ-1:0]        req_grant;
    logic                    cdb_stall = 1'b0;
    logic                    flush = 1'b0;
    logic [N_CDB-1:0]        cdb_valid;
    logic [N_CDB-1:0][TB-1:0] cdb_tag;
    logic [N_CDB-1:0][XL-1:0] cdb_data;
    logic [1:0]              grant_count;
    logic [1:0]              rr_ptr;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cdb_arbiter #(
        .N_REQ(N_REQ), .N_CDB(N_CDB), .TAG_BITS(TB), .XLEN(XL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_tag(req_tag),
        .req_data(req_data),
        .req_grant(req_grant),
        .cdb_stall(cdb_stall),
        .flush(flush),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .cdb_data(cdb_data),
        .grant_count(grant_count),
        .rr_ptr(rr_ptr)
    );

    // Model: grant the first N_CDB eligible requesters in rotated order.
    int                      m_ptr = 0;
    bit                      m_ready = 1'b0;
    logic [N_CDB-1:0]        m_valid;
    logic [N_CDB-1:0][TB-1:0] m_tag;
    logic [N_CDB-1:0][XL-1:0] m_data;
    logic [N_REQ-1:0]        e_grant;
    int                      e_cnt;
    int                      e_sel [0:N_CDB-1];
    int                      e_last;
    int                      e_i;

    always_comb begin
        e_grant = '0;
        e_cnt   = 0;
        e_last  = 0;
        e_i     = 0;
        for (int k = 0; k < N_CDB; k++) e_sel[k] = 0;
        if (!reset && !flush && !cdb_stall) begin
            for (int j = 0; j < N_REQ; j++) begin
                e_i = (m_ptr + j) % N_REQ;
                if (req_valid[e_i] && req_tag[e_i] != 0 && e_cnt < N_CDB) begin
                    e_grant[e_i] = 1'b1;
                    e_sel[e_cnt] = e_i;
                    e_last = e_i;
                    e_cnt = e_cnt + 1;
                end
            end
        end
    end

    always @(posedge clock) begin
        m_ready <= 1'b1;
        if (reset || flush) begin
            m_valid <= '0;
            m_tag   <= '0;
            m_data  <= '0;
            m_ptr   <= 0;
        end else if (!cdb_stall) begin
            for (int k = 0; k < N_CDB; k++) begin
                m_valid[k] <= (e_cnt > k);
                m_tag[k]   <= (e_cnt > k) ? req_tag[e_sel[k]] : '0;
                m_data[k]  <= (e_cnt > k) ? req_data[e_sel[k]] : '0;
            end
            if (e_cnt > 0) m_ptr <= (e_last + 1) % N_REQ;
        end
    end

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic setv(input logic [3:0] v, input logic [5:0] t0,
                        input logic [5:0] t1, input logic [5:0] t2,
                        input logic [5:0] t3, input logic s, input logic f);
        req_valid = v;
        req_tag   = {t3, t2, t1, t0};
        for (int i = 0; i < N_REQ; i++) begin
            req_data[i] = 32'hD000_0000 + 32'(i * 256) + 32'(req_tag[i]);
        end
        cdb_stall = s;
        flush     = f;
    endtask

    // Sample at the falling edge: compare the DUT against the model.
    task automatic at_neg();
        @(negedge clock);
        if (m_ready) begin
            chk("m_grant", 128'(req_grant), 128'(e_grant));
            chk("m_count", 128'(grant_count), 128'(e_cnt));
            chk("m_valid", 128'(cdb_valid), 128'(m_valid));
            chk("m_tag", 128'(cdb_tag), 128'(m_tag));
            chk("m_data", 128'(cdb_data), 128'(m_data));
            chk("m_ptr", 128'(rr_ptr), 128'(m_ptr));
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset with everybody requesting.
        setv(4'b1111, 6'd5, 6'd6, 6'd7, 6'd8, 1'b0, 1'b0);
        adv();
        at_neg();
        chk("rst_grant", 128'(req_grant), 128'(4'b0000));
        chk("rst_valid", 128'(cdb_valid), 128'(2'b00));
        chk("rst_ptr", 128'(rr_ptr), 128'(2'd0));
        adv();
        at_neg();
        chk("rst_grant2", 128'(req_grant), 128'(4'b0000));
        adv();
        reset = 1'b0;

        // Full contention.
        at_neg();
        chk("fc0_grant", 128'(req_grant), 128'(4'b0011));
        chk("fc0_count", 128'(grant_count), 128'(2'd2));
        adv();
        chk("fc0_tag", 128'(cdb_tag), 128'({6'd6, 6'd5}));
        chk("fc0_data1", 128'(cdb_data[1]), 128'(32'hD000_0106));
        chk("fc0_ptr", 128'(rr_ptr), 128'(2'd2));
        setv(4'b1100, 6'd5, 6'd6, 6'd7, 6'd8, 1'b0, 1'b0);
        at_neg();
        chk("fc1_grant", 128'(req_grant), 128'(4'b1100));
        adv();
        chk("fc1_tag", 128'(cdb_tag), 128'({6'd8, 6'd7}));
        chk("fc1_ptr", 128'(rr_ptr), 128'(2'd0));

        // Move rr_ptr to 3, then wrap around.
        setv(4'b0100, 6'd0, 6'd0, 6'd11, 6'd0, 1'b0, 1'b0);
        at_neg();
        adv();
        chk("pre_wrap_ptr", 128'(rr_ptr), 128'(2'd3));
        setv(4'b1001, 6'd9, 6'd0, 6'd0, 6'd12, 1'b0, 1'b0);
        at_neg();
        chk("wrap_grant", 128'(req_grant), 128'(4'b1001));
        adv();
        chk("wrap_tag", 128'(cdb_tag), 128'({6'd9, 6'd12}));
        chk("wrap_ptr", 128'(rr_ptr), 128'(2'd1));

        // Stall holds outputs and pointer.
        setv(4'b0110, 6'd0, 6'd20, 6'd21, 6'd0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk("stall_grant", 128'(req_grant), 128'(4'b0000));
            adv();
            chk("stall_valid", 128'(cdb_valid), 128'(2'b11));
            chk("stall_tag", 128'(cdb_tag), 128'({6'd9, 6'd12}));
            chk("stall_ptr", 128'(rr_ptr), 128'(2'd1));
        end
        cdb_stall = 1'b0;
        at_neg();
        chk("unstall_grant", 128'(req_grant), 128'(4'b0110));
        adv();
        chk("unstall_tag", 128'(cdb_tag), 128'({6'd21, 6'd20}));
        chk("unstall_ptr", 128'(rr_ptr), 128'(2'd3));

        // Idle cycle clears the broadcast.
        setv(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        at_neg();
        adv();
        chk("idle_valid", 128'(cdb_valid), 128'(2'b00));
        chk("idle_tag", 128'(cdb_tag), 128'(12'd0));

        // Tag zero is never granted.
        setv(4'b0011, 6'd0, 6'd4, 6'd0, 6'd0, 1'b0, 1'b0);
        at_neg();
        chk("tz_grant", 128'(req_grant), 128'(4'b0010));
        chk("tz_count", 128'(grant_count), 128'(2'd1));
        adv();
        chk("tz_valid", 128'(cdb_valid), 128'(2'b01));
        chk("tz_tag", 128'(cdb_tag), 128'({6'd0, 6'd4}));
        chk("tz_ptr", 128'(rr_ptr), 128'(2'd2));

        // Flush mid-stream.
        setv(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4, 1'b0, 1'b0);
        at_neg();
        adv();
        chk("fl_pre_valid", 128'(cdb_valid), 128'(2'b11));
        chk("fl_pre_ptr", 128'(rr_ptr), 128'(2'd0));
        at_neg();
        adv();
        chk("fl_pre_ptr2", 128'(rr_ptr), 128'(2'd2));
        flush = 1'b1;
        at_neg();
        chk("fl_grant", 128'(req_grant), 128'(4'b0000));
        adv();
        chk("fl_valid", 128'(cdb_valid), 128'(2'b00));
        chk("fl_ptr", 128'(rr_ptr), 128'(2'd0));

        // Flush wins over stall.
        flush = 1'b0;
        at_neg();
        adv();
        chk("fs_pre_valid", 128'(cdb_valid), 128'(2'b11));
        flush = 1'b1;
        cdb_stall = 1'b1;
        at_neg();
        chk("fs_grant", 128'(req_grant), 128'(4'b0000));
        adv();
        chk("fs_valid", 128'(cdb_valid), 128'(2'b00));
        chk("fs_ptr", 128'(rr_ptr), 128'(2'd0));

        // Mixed traffic checked against the model only.
        for (int c = 0; c < 60; c++) begin
            setv(4'($urandom), 6'($urandom_range(0, 9)),
                 6'($urandom_range(0, 9)), 6'($urandom_range(0, 9)),
                 6'($urandom_range(0, 9)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0));
            at_neg();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
